relogio_ctrl: RTL and testbench

Mode/sequencing controller for the clock's seconds, minutes and hours counters. In RUN it generates the 1 Hz seconds increment and ripples counter carries upward. In SET modes it freezes timekeeping and turns debounced button presses into increment pulses for the selected field. It also provides a blink enable for the display of the field being edited.

---
 rtl/relogio_ctrl_if.sv | 22 ++
 rtl/relogio_ctrl.sv | 170 +++++++++++++++++
 tb/tb_relogio_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/relogio_ctrl_if.sv
// Button, carry and display-control signals between the clock datapath and its controller.
interface relogio_ctrl_if;
  logic       btn_mode_i;
  logic       btn_adj_i;
  logic       carry_seg_i;
  logic       carry_min_i;
  logic       inc_seg_o;
  logic       inc_min_o;
  logic       inc_hor_o;
  logic [1:0] mode_o;
  logic       blink_o;

  modport master (
    output btn_mode_i, btn_adj_i, carry_seg_i, carry_min_i,
    input  inc_seg_o, inc_min_o, inc_hor_o, mode_o, blink_o
  );

  modport slave (
    input  btn_mode_i, btn_adj_i, carry_seg_i, carry_min_i,
    output inc_seg_o, inc_min_o, inc_hor_o, mode_o, blink_o
  );
endinterface

// File: rtl/relogio_ctrl.sv
// Clock mode/sequencing controller: 1 Hz tick and carry ripple in RUN,
// debounced button editing with auto-repeat and field blink in SET modes.
module relogio_deb #(
  parameter int unsigned DEB_CYC = 1000000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic raw_i,
  output logic lvl_o
);
  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          diff;

  assign diff = (sync[1] != lvl_o);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync  <= '0;
      cnt   <= '0;
      lvl_o <= 1'b0;
    end else begin
      sync <= {sync[0], raw_i};
      if (diff && cnt == CW'(DEB_CYC - 1)) begin
        lvl_o <= sync[1];
        cnt   <= '0;
      end else if (diff) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module relogio_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned DEB_CYC   = 1000000,
  parameter int unsigned RPT_DLY   = 25000000,
  parameter int unsigned RPT_PER   = 10000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  relogio_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

  localparam int NUM_BTN  = 2;
  localparam int BTN_MODE = 0;
  localparam int BTN_ADJ  = 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(RPT_DLY + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [NUM_BTN-1:0] raw, lvl, lvl_q, ev;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          armed_q, armed_d;
  logic          blink_q, blink_d;
  logic          seg_q, seg_d, min_q, min_d, hor_q, hor_d;
  logic          mode_ev, in_set, press, rpt_fire, adj_ev;

  assign raw = {bus.btn_adj_i, bus.btn_mode_i};

  relogio_deb #(.DEB_CYC(DEB_CYC)) u_deb [NUM_BTN-1:0] (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .raw_i  (raw),
    .lvl_o  (lvl)
  );

  // Event is the first cycle of a new accepted-high level; releases are silent.
  assign ev = lvl & ~lvl_q;

  // Mode wins a tie, so adj activity is masked whenever mode fires.
  assign mode_ev  = ev[BTN_MODE];
  assign in_set   = (state_q != RUN);
  assign press    = in_set & ev[BTN_ADJ] & ~mode_ev;
  assign rpt_fire = in_set & armed_q & lvl[BTN_ADJ] & ~mode_ev & (rpt_q == RW'(RPT_DLY));
  assign adj_ev   = press | rpt_fire;

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    rpt_d   = '0;
    armed_d = armed_q;
    blink_d = 1'b1;
    bcnt_d  = '0;
    seg_d   = 1'b0;
    min_d   = 1'b0;
    hor_d   = 1'b0;

    if (mode_ev) begin
      case (state_q)
        RUN:     state_d = SET_HOR;
        SET_HOR: state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN;
      endcase
    end

    // Repeat needs a fresh press inside the current SET state.
    if (mode_ev || !lvl[BTN_ADJ]) armed_d = 1'b0;
    else if (press)               armed_d = 1'b1;

    if (press)                                     rpt_d = RW'(1);
    else if (rpt_fire)                             rpt_d = RW'(RPT_DLY - RPT_PER + 1);
    else if (armed_q && lvl[BTN_ADJ] && !mode_ev)  rpt_d = rpt_q + RW'(1);

    case (state_q)
      RUN: begin
        seg_d = (pre_q == PW'(TICK_DIV - 1));
        min_d = bus.carry_seg_i;
        hor_d = bus.carry_min_i;
        if (!mode_ev && !seg_d) pre_d = pre_q + PW'(1);
      end
      SET_HOR: hor_d = adj_ev;
      SET_MIN: min_d = adj_ev;
      default: seg_d = adj_ev;
    endcase

    // Any state entry or adjustment restarts the blink phase visible.
    if (in_set && !mode_ev && !adj_ev) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RUN;
      pre_q   <= '0;
      rpt_q   <= '0;
      bcnt_q  <= '0;
      armed_q <= 1'b0;
      blink_q <= 1'b1;
      seg_q   <= 1'b0;
      min_q   <= 1'b0;
      hor_q   <= 1'b0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rpt_q   <= rpt_d;
      bcnt_q  <= bcnt_d;
      armed_q <= armed_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hor_q   <= hor_d;
      lvl_q   <= lvl;
    end
  end

  assign bus.inc_seg_o = seg_q;
  assign bus.inc_min_o = min_q;
  assign bus.inc_hor_o = hor_q;
  assign bus.mode_o    = state_q;
  assign bus.blink_o   = blink_q;
endmodule

// File: tb/tb_relogio_ctrl.sv
// Scoreboard bench for relogio_ctrl: a time-based reference model predicts every
// output cycle, a negedge monitor compares, plus directed pulse-count checks.
module tb_relogio_ctrl;
  localparam int TICK_DIV = 10, DEB_CYC = 4, RPT_DLY = 20, RPT_PER = 5, BLINK_DIV = 6;
  localparam logic [5:0] RST_OUT = 6'b000_00_1;

  logic clk = 1'b0, rstn = 1'b0;
  relogio_ctrl_if bus();

  relogio_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC), .RPT_DLY(RPT_DLY),
                 .RPT_PER(RPT_PER), .BLINK_DIV(BLINK_DIV)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_seg = 0, n_min = 0, n_hor = 0;
  logic [5:0] exp_q[$];

  function automatic logic [5:0] dut_out();
    return {bus.inc_seg_o, bus.inc_min_o, bus.inc_hor_o, bus.mode_o, bus.blink_o};
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, want);
    end
  endtask

  // Reference model: events by run-length over synchronised samples, timing
  // from reference cycle stamps (run start, press, blink restart).
  int n, state, run_start, blink_ref, press_cyc;
  bit armed;
  int run_len[2];
  bit acc[2], evp[2];
  logic [1:0] rawh[$];

  task automatic mreset();
    n = 0; state = 0; run_start = 0; blink_ref = 0; press_cyc = 0; armed = 0;
    for (int b = 0; b < 2; b++) begin run_len[b] = 0; acc[b] = 0; evp[b] = 0; end
    rawh.delete(); rawh.push_back(2'b00); rawh.push_back(2'b00);
  endtask

  task automatic mstep();
    bit mev, aev, lvl, fire, es, em, eh, eb;
    logic [1:0] v;
    int d;
    n++;
    mev = evp[0]; aev = evp[1]; lvl = acc[1];
    es = 0; em = 0; eh = 0;
    if (state == 0) begin
      es = (n > run_start) && ((n - run_start) % TICK_DIV == 0);
      em = bus.carry_seg_i;
      eh = bus.carry_min_i;
    end else if (!mev) begin
      d = n - press_cyc;
      fire = aev || (armed && lvl && d >= RPT_DLY && (d - RPT_DLY) % RPT_PER == 0);
      if (aev) begin armed = 1; press_cyc = n; end
      else if (!lvl) armed = 0;
      if (fire) begin
        blink_ref = n;
        if (state == 1) eh = 1; else if (state == 2) em = 1; else es = 1;
      end
    end
    if (mev) begin
      state = (state + 1) % 4;
      armed = 0;
      if (state == 0) run_start = n; else blink_ref = n;
    end
    eb = (state == 0) ? 1'b1 : (((n - blink_ref) / BLINK_DIV) % 2 == 0);
    exp_q.push_back({es, em, eh, 2'(state), eb});
    rawh.push_back({bus.btn_adj_i, bus.btn_mode_i});
    v = rawh.pop_front();
    for (int b = 0; b < 2; b++) begin
      evp[b] = 0;
      if (v[b] != acc[b]) begin
        run_len[b]++;
        if (run_len[b] == DEB_CYC) begin acc[b] = v[b]; evp[b] = v[b]; run_len[b] = 0; end
      end else run_len[b] = 0;
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin mreset(); exp_q.delete(); end
      else mstep();
    end
  end

  // Monitor: one scoreboard comparison per cycle.
  initial forever begin
    logic [5:0] e;
    @(negedge clk);
    if (!rstn || exp_q.size() == 0) e = RST_OUT;
    else e = exp_q.pop_front();
    total++;
    if (dut_out() !== e) begin
      bad++;
      $display("FAIL out at %0t: got seg/min/hor/mode/blink=%b want %b", $time, dut_out(), e);
    end
    if (bus.inc_seg_o) n_seg++;
    if (bus.inc_min_o) n_min++;
    if (bus.inc_hor_o) n_hor++;
  end

  task automatic press(input bit m, input bit a, input int hold, input int gap);
    bus.btn_mode_i = m; bus.btn_adj_i = a;
    repeat (hold) @(negedge clk);
    bus.btn_mode_i = 0; bus.btn_adj_i = 0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int s0, m0, h0, mh, ah;
    bus.btn_mode_i = 0; bus.btn_adj_i = 0; bus.carry_seg_i = 0; bus.carry_min_i = 0;
    repeat (3) @(negedge clk);
    #2 rstn = 1;

    // Free-running ticks after reset.
    s0 = n_seg;
    repeat (35) @(negedge clk);
    chk("tick_count", n_seg - s0, 3);

    // Carry forwarding in RUN.
    bus.carry_seg_i = 1; @(negedge clk); bus.carry_seg_i = 0;
    chk("carry_seg_fwd", bus.inc_min_o, 1);
    @(negedge clk); chk("carry_seg_1cyc", bus.inc_min_o, 0);
    bus.carry_min_i = 1; @(negedge clk); bus.carry_min_i = 0;
    chk("carry_min_fwd", bus.inc_hor_o, 1);
    @(negedge clk); chk("carry_min_1cyc", bus.inc_hor_o, 0);

    // Mode stepping, carry dropped in SET_MIN, return to RUN, glitch.
    press(1, 0, 8, 12); chk("mode_1", bus.mode_o, 1);
    press(1, 0, 8, 12); chk("mode_2", bus.mode_o, 2);
    m0 = n_min;
    bus.carry_seg_i = 1; @(negedge clk); bus.carry_seg_i = 0;
    repeat (3) @(negedge clk);
    chk("carry_in_set", n_min - m0, 0);
    press(1, 0, 8, 12); chk("mode_3", bus.mode_o, 3);
    press(1, 0, 8, 25); chk("mode_0", bus.mode_o, 0);
    press(1, 0, 2, 12); chk("mode_glitch", bus.mode_o, 0);

    // Auto-repeat in SET_MIN.
    press(1, 0, 8, 12); press(1, 0, 8, 12);
    chk("mode_setmin", bus.mode_o, 2);
    s0 = n_seg; m0 = n_min; h0 = n_hor;
    press(0, 1, 40, 20);
    chk("rpt_min_pulses", n_min - m0, 5);
    chk("rpt_no_seg", n_seg - s0, 0);
    chk("rpt_no_hor", n_hor - h0, 0);

    // Simultaneous mode+adj in SET_SEC.
    press(1, 0, 8, 12); chk("mode_setsec", bus.mode_o, 3);
    s0 = n_seg;
    press(1, 1, 8, 0);
    chk("tie_mode_wins", bus.mode_o, 0);
    chk("tie_no_adj", n_seg - s0, 0);
    repeat (12) @(negedge clk);

    // Blink in SET_HOR with a short adj press.
    press(1, 0, 8, 30); chk("mode_sethor", bus.mode_o, 1);
    h0 = n_hor;
    press(0, 1, 6, 20);
    chk("adj_hor_pulse", n_hor - h0, 1);

    // Asynchronous reset in the middle of a repeat.
    press(1, 0, 8, 12);
    bus.btn_adj_i = 1;
    repeat (30) @(negedge clk);
    @(posedge clk); #2 rstn = 0; #1;
    chk("async_rst", dut_out(), RST_OUT);
    bus.btn_adj_i = 0;
    repeat (3) @(negedge clk);
    #2 rstn = 1;

    // Randomised buttons and carries.
    mh = 0; ah = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (mh == 0) begin bus.btn_mode_i = ($urandom_range(0, 5) == 0); mh = $urandom_range(1, 30); end
      else mh--;
      if (ah == 0) begin bus.btn_adj_i = $urandom_range(0, 1); ah = $urandom_range(1, 60); end
      else ah--;
      bus.carry_seg_i = !bus.carry_seg_i && ($urandom_range(0, 9) == 0);
      bus.carry_min_i = !bus.carry_min_i && ($urandom_range(0, 12) == 0);
    end
    bus.btn_mode_i = 0; bus.btn_adj_i = 0; bus.carry_seg_i = 0; bus.carry_min_i = 0;
    repeat (20) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
